// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer: one holding register per channel, full throughput.
// Optional per-channel saturating transfer counters when DEMUX_CNT_EN is defined.
module demux_1to4_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        select,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out_0,
  output logic [DATA_W-1:0] data_out_1,
  output logic [DATA_W-1:0] data_out_2,
  output logic [DATA_W-1:0] data_out_3,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [31:0]       xfer_cnt
`endif
);

  // Handshake: a word moves on any rising edge where valid && ready; valid never
  // waits on ready, and an offered word/select stays put until it is taken.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

  chan_state_t       state_q [4];
  chan_state_t       state_d [4];
  logic [DATA_W-1:0] data_q  [4];
  logic [DATA_W-1:0] data_d  [4];
  logic [3:0]        out_xfer;
  logic              in_xfer;

  always_comb begin
    in_ready = (state_q[select] == EMPTY) || out_ready[select];
    in_xfer  = in_valid && in_ready;
    out_xfer = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      state_d[i]  = state_q[i];
      data_d[i]   = data_q[i];
      out_xfer[i] = (state_q[i] == FULL) && out_ready[i];
      if (out_xfer[i]) begin
        state_d[i] = EMPTY;
      end
      // A load on the draining channel overrides the clear, keeping 1 word/cycle.
      if (in_xfer && (select == 2'(i))) begin
        state_d[i] = FULL;
        data_d[i]  = data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      out_valid[i] = (state_q[i] == FULL);
    end
  end

  assign data_out_0 = data_q[0];
  assign data_out_1 = data_q[1];
  assign data_out_2 = data_q[2];
  assign data_out_3 = data_q[3];

`ifdef DEMUX_CNT_EN
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (out_xfer[i] && (cnt_q[i] != 8'hFF)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign xfer_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Directed bench for demux_1to4_reg plus a pseudo-random phase scored against
// per-channel expected queues; counter checks compile in with DEMUX_CNT_EN.
module tb_demux_1to4_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic [1:0]  select;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_out_0;
  logic [31:0] data_out_1;
  logic [31:0] data_out_2;
  logic [31:0] data_out_3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
`ifdef DEMUX_CNT_EN
  logic [31:0] xfer_cnt;
`endif

  logic [31:0] dout [4];
  logic [31:0] exp_q [4][$];
  int          cnt_m [4];
  int          n_vec;
  int          n_err;

  demux_1to4_reg #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .select     (select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .data_out_3 (data_out_3),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef DEMUX_CNT_EN
    ,
    .xfer_cnt   (xfer_cnt)
`endif
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    dout[0] = data_out_0;
    dout[1] = data_out_1;
    dout[2] = data_out_2;
    dout[3] = data_out_3;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: apply inputs just after a falling edge and let combinational outputs settle.
  task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] d,
                       input logic [3:0] ordy);
    in_valid  = v;
    select    = sel;
    data_in   = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One scored cycle: expected valid/ready/data come from the queues, then the queues advance.
  task automatic model_cycle(input logic v, input logic [1:0] sel, input logic [31:0] d,
                             input logic [3:0] ordy);
    logic [3:0] exp_ov;
    logic       exp_rdy;
    drive(v, sel, d, ordy);
    for (int ch = 0; ch < 4; ch++) exp_ov[ch] = (exp_q[ch].size() != 0);
    check("rnd_out_valid", {28'd0, out_valid}, {28'd0, exp_ov});
    exp_rdy = !exp_ov[sel] || ordy[sel];
    check("rnd_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    for (int ch = 0; ch < 4; ch++) begin
      if (exp_ov[ch]) check($sformatf("rnd_data_%0d", ch), dout[ch], exp_q[ch][0]);
    end
    for (int ch = 0; ch < 4; ch++) begin
      if (exp_ov[ch] && ordy[ch]) begin
        void'(exp_q[ch].pop_front());
        cnt_m[ch]++;
      end
    end
    if (v && exp_rdy) exp_q[sel].push_back(d);
    cyc();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int ch = 0; ch < 4; ch++) cnt_m[ch] = 0;
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 4'b0000);
    check("reset_out_valid", {28'd0, out_valid}, 32'd0);
    check("reset_data_out_2", data_out_2, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // First word after reset lands on channel 2 with 1-cycle latency
    drive(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
    check("first_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    drive(1'b0, 2'd2, 32'h0, 4'b0000);
    check("first_out_valid", {28'd0, out_valid}, 32'h4);
    check("first_data_out_2", data_out_2, 32'hDEADBEEF);
    check("first_in_ready_full", {31'd0, in_ready}, 32'd0);

    // Channel 1 fill, then drain and refill in the same cycle
    drive(1'b1, 2'd1, 32'h11111111, 4'b0000);
    cyc();
    check("ch1_fill_valid", {28'd0, out_valid}, 32'h6);
    check("ch1_fill_data", data_out_1, 32'h11111111);
    drive(1'b1, 2'd1, 32'h22222222, 4'b0010);
    check("passthru_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    check("passthru_valid", {28'd0, out_valid}, 32'h6);
    check("passthru_data", data_out_1, 32'h22222222);

    // Stalled channel holds its word and refuses input
    drive(1'b1, 2'd1, 32'h44444444, 4'b0000);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    check("stall_data", data_out_1, 32'h22222222);
    check("stall_valid", {28'd0, out_valid}, 32'h6);

    // in_valid low changes nothing, in_ready still reflects the selected channel
    drive(1'b0, 2'd2, 32'h55555555, 4'b0000);
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    check("idle_data_out_2", data_out_2, 32'hDEADBEEF);
    check("idle_valid", {28'd0, out_valid}, 32'h6);

    drive(1'b0, 2'd0, 32'h0, 4'b0110);
    cyc();
    check("drain_valid", {28'd0, out_valid}, 32'h0);

    // A full, stalled channel 0 does not block channel 3
    drive(1'b1, 2'd0, 32'h0A0A0A0A, 4'b0000);
    cyc();
    drive(1'b1, 2'd3, 32'h33333333, 4'b0000);
    check("indep_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    check("indep_valid", {28'd0, out_valid}, 32'h9);
    check("indep_data_out_0", data_out_0, 32'h0A0A0A0A);
    check("indep_data_out_3", data_out_3, 32'h33333333);
    drive(1'b0, 2'd0, 32'h0, 4'b1000);
    cyc();
    check("drain3_valid", {28'd0, out_valid}, 32'h1);
    check("drain3_data_out_0", data_out_0, 32'h0A0A0A0A);

    // Fill all four, then reset asynchronously between edges
    drive(1'b1, 2'd1, 32'hA1A1A1A1, 4'b0000);
    cyc();
    drive(1'b1, 2'd2, 32'hA2A2A2A2, 4'b0000);
    cyc();
    drive(1'b1, 2'd3, 32'hA3A3A3A3, 4'b0000);
    cyc();
    check("all_full_valid", {28'd0, out_valid}, 32'hF);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {28'd0, out_valid}, 32'h0);
    check("async_rst_data_out_0", data_out_0, 32'h0);
    check("async_rst_data_out_1", data_out_1, 32'h0);
    check("async_rst_data_out_2", data_out_2, 32'h0);
    check("async_rst_data_out_3", data_out_3, 32'h0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 2'd0, 32'hABCDABCD, 4'b0000);
    cyc();
    check("rst_no_xfer_valid", {28'd0, out_valid}, 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 2'd0, 32'h0F0F0F0F, 4'b0001);
    cyc();
    check("post_rst_valid", {28'd0, out_valid}, 32'h1);
    check("post_rst_data", data_out_0, 32'h0F0F0F0F);

    // Pseudo-random traffic scored against per-channel expected queues
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 4'b0000);
    cyc();
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      model_cycle(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15)));
    end
    for (int n = 0; n < 300; n++) begin
      model_cycle(1'b1, 2'd3, $urandom, 4'b1000);
    end
`ifdef DEMUX_CNT_EN
    for (int ch = 0; ch < 4; ch++) begin
      check($sformatf("xfer_cnt_%0d", ch), {24'd0, xfer_cnt[ch*8 +: 8]},
            (cnt_m[ch] > 255) ? 32'd255 : 32'(cnt_m[ch]));
    end
    check("xfer_cnt_3_sat", {24'd0, xfer_cnt[31:24]}, 32'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
